pc_gen_unit: RTL

Parametrised program-counter generation unit for the fetch stage; the successor to the single-register PC block. Holds the architectural fetch PC and selects the next one from trap, execute-stage redirect, decode-stage return prediction, stall hold, or sequential increment, in fixed priority. Contains a circular return-address stack (RAS) that predicts the targets of function returns at decode time.

---
 rtl/pc_pkg.sv | 22 ++
 rtl/pc_ras.sv | 68 ++++++
 rtl/pc_gen_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared defaults, next-PC source enum and RAS sizing helper
package pc_pkg;

  localparam int          DEF_XLEN         = 64;
  localparam int          DEF_INST_BYTES   = 4;
  localparam logic [63:0] DEF_RESET_VECTOR = 64'h0;

  typedef enum logic [2:0] {
    SRC_RESET,
    SRC_TRAP,
    SRC_EX,
    SRC_RAS,
    SRC_HOLD,
    SRC_SEQ
  } pc_src_e;

  // Count must represent 0..depth inclusive, hence one bit beyond the index width.
  function automatic int ras_count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack with saturating count
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push, push_data     push a return address
//   pop                 pop the top entry
//   top                 current top entry (valid when count > 0)
//   count               number of valid entries, saturates at RAS_DEPTH
//   underflow           one-cycle pulse: pop requested while empty
module pc_ras
  import pc_pkg::*;
#(
  parameter int RAS_DEPTH = 8,
  parameter int XLEN      = DEF_XLEN
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   push,
  input  logic                                   pop,
  input  logic [XLEN-1:0]                        push_data,
  output logic [XLEN-1:0]                        top,
  output logic [ras_count_width(RAS_DEPTH)-1:0]  count,
  output logic                                   underflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = ras_count_width(RAS_DEPTH);

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   ptr;      // next slot to write; top lives at ptr-1
  logic [PW-1:0]   top_idx;
  logic            empty;
  logic            full;
  logic            swap;     // call+return together on a non-empty stack

  assign top_idx = ptr - 1'b1;
  assign empty   = (count == '0);
  assign full    = (count == CW'(RAS_DEPTH));
  assign swap    = push && pop && !empty;
  assign top     = mem[top_idx];

  // Entry contents carry no reset; only pointer and count define validity.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      if (swap) mem[top_idx] <= push_data;
      else      mem[ptr]     <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      underflow <= pop && empty;
      if (push && !swap) begin
        // When full the write above lands on the oldest slot.
        ptr <= ptr + 1'b1;
        if (!full) count <= count + 1'b1;
      end else if (pop && !push && !empty) begin
        ptr   <= ptr - 1'b1;
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// rtl/pc_gen_unit.sv - fetch PC register with prioritized next-PC select and RAS
//
// Ports:
//   clk, rst                                  clock, synchronous active-high reset
//   stall                                     hold the PC
//   trap_valid, trap_target                   trap redirect (highest priority)
//   ex_redirect_valid, ex_redirect_target     execute-stage mispredict redirect
//   dec_call, dec_ret_addr                    decode saw a call; push return address
//   dec_ret                                   decode saw a return; pop RAS and redirect
//   pc, pc_next                               registered PC, combinational next PC
//   pc_redirected                             high one cycle after a non-sequential load
//   pc_misaligned                             PC not a multiple of INST_BYTES
//   ras_count, ras_underflow                  RAS occupancy and empty-pop pulse
module pc_gen_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter int              INST_BYTES   = DEF_INST_BYTES,
  parameter int              RAS_DEPTH    = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   stall,
  input  logic                                   trap_valid,
  input  logic [XLEN-1:0]                        trap_target,
  input  logic                                   ex_redirect_valid,
  input  logic [XLEN-1:0]                        ex_redirect_target,
  input  logic                                   dec_call,
  input  logic [XLEN-1:0]                        dec_ret_addr,
  input  logic                                   dec_ret,
  output logic [XLEN-1:0]                        pc,
  output logic [XLEN-1:0]                        pc_next,
  output logic                                   pc_redirected,
  output logic                                   pc_misaligned,
  output logic [ras_count_width(RAS_DEPTH)-1:0]  ras_count,
  output logic                                   ras_underflow
);

  localparam int AW = $clog2(INST_BYTES);

  pc_src_e         src;
  logic            wrong_path;
  logic            ras_push;
  logic            ras_pop;
  logic [XLEN-1:0] ras_top;

  // Decode events behind a trap or execute redirect are on the wrong path.
  assign wrong_path = trap_valid || ex_redirect_valid;
  assign ras_push   = dec_call && !wrong_path;
  assign ras_pop    = dec_ret  && !wrong_path;

  pc_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .XLEN      (XLEN)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (dec_ret_addr),
    .top       (ras_top),
    .count     (ras_count),
    .underflow (ras_underflow)
  );

  always_comb begin
    src = SRC_SEQ;
    if (rst)                              src = SRC_RESET;
    else if (trap_valid)                  src = SRC_TRAP;
    else if (ex_redirect_valid)           src = SRC_EX;
    else if (dec_ret && ras_count != '0)  src = SRC_RAS;
    else if (stall)                       src = SRC_HOLD;
  end

  always_comb begin
    pc_next = pc + XLEN'(INST_BYTES);
    case (src)
      SRC_RESET: pc_next = RESET_VECTOR;
      SRC_TRAP:  pc_next = trap_target;
      SRC_EX:    pc_next = ex_redirect_target;
      SRC_RAS:   pc_next = ras_top;
      SRC_HOLD:  pc_next = pc;
      default:   pc_next = pc + XLEN'(INST_BYTES);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_VECTOR;
      pc_redirected <= 1'b0;
    end else begin
      pc            <= pc_next;
      pc_redirected <= (src == SRC_TRAP) || (src == SRC_EX) || (src == SRC_RAS);
    end
  end

  assign pc_misaligned = |pc[AW-1:0];

endmodule
